// File: rtl/lcd_byte_writer_if.sv
// Request channel into lcd_byte_writer: one {rs, data} byte per in_valid && in_ready handshake.
// The sequencer side drives through master; the writer consumes through slave.
interface lcd_byte_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_byte_writer.sv
// HD44780 8-bit bus writer: buffers {rs,data} bytes and paces setup/EN/hold/exec-wait; bus loads 1 cycle after accept, EN high 3..27.
// Backpressure: in_ready = !fifo_full (no pass-through); LCD_INIT_SEQ_EN adds power-up delay + 0x38,0x0C,0x01,0x06 with in_ready held low.
module lcd_byte_writer #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 25,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int FIFO_DEPTH     = 4,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_byte_writer_if.slave  req,
  output logic              busy,
  output logic [7:0]        lcd_data,
  output logic              lcd_en,
  output logic              lcd_rs,
  output logic              lcd_rw
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (LONG_WAIT_CYC > POWERUP_CYC) ? LONG_WAIT_CYC : POWERUP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYC);
  localparam logic [CW-1:0] EN_L    = CW'(EN_CYC);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] SHORT_L = CW'(SHORT_WAIT_CYC);
  localparam logic [CW-1:0] LONG_L  = CW'(LONG_WAIT_CYC);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);

`ifdef LCD_INIT_SEQ_EN
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, PWRUP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cnt_last;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            fifo_full, fifo_empty;
  logic            push, pop, start;

  logic            src_vld, src_rs, src_init, src_long;
  logic [7:0]      src_data;
  logic            long_q;
  logic            init_busy;

  assign fifo_full  = (count == DEPTH_L);
  assign fifo_empty = (count == '0);
  assign cnt_last   = (cnt_q == CW'(1));

  // ---------------- request FIFO ----------------
  assign push = req.in_valid && req.in_ready;
  assign pop  = start && !src_init;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req.in_rs, req.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- byte source: init ROM first, then FIFO head ----------------
`ifdef LCD_INIT_SEQ_EN
  logic [2:0] init_idx_q;
  logic       cur_init_q;
  logic [7:0] init_byte;

  always_comb begin
    unique case (init_idx_q)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end

  // init_idx advances only when a byte's WAIT finishes, so in_ready stays low through the last wait
  assign init_busy = (init_idx_q != 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx_q <= 3'd0;
      cur_init_q <= 1'b0;
    end else begin
      if (start) cur_init_q <= src_init;
      if (state_q == WAIT && cnt_last && cur_init_q) init_idx_q <= init_idx_q + 3'd1;
    end
  end

  always_comb begin
    src_init = init_busy;
    src_vld  = init_busy || !fifo_empty;
    src_rs   = init_busy ? 1'b0 : mem[rd_ptr][8];
    src_data = init_busy ? init_byte : mem[rd_ptr][7:0];
  end
`else
  assign init_busy = 1'b0;

  always_comb begin
    src_init = 1'b0;
    src_vld  = !fifo_empty;
    src_rs   = mem[rd_ptr][8];
    src_data = mem[rd_ptr][7:0];
  end
`endif

  // clear (0x01) and home (0x02/0x03) need the long execution time
  assign src_long = !src_rs && (src_data == 8'h01 || src_data == 8'h02 || src_data == 8'h03);

  assign req.in_ready = !fifo_full && !init_busy;

  // ---------------- timing FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LCD_INIT_SEQ_EN
      state_q <= PWRUP;
      cnt_q   <= CW'(POWERUP_CYC);
`else
      state_q <= IDLE;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (src_vld) begin
          start   = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_L;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          state_d = PULSE;
          cnt_d   = EN_L;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_last) begin
          state_d = HOLD;
          cnt_d   = HOLD_L;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_last) begin
          state_d = WAIT;
          cnt_d   = long_q ? LONG_L : SHORT_L;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef LCD_INIT_SEQ_EN
      PWRUP: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // bus registers change only on the IDLE->SETUP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      long_q   <= 1'b0;
    end else if (start) begin
      lcd_rs   <= src_rs;
      lcd_data <= src_data;
      long_q   <= src_long;
    end
  end

  assign lcd_en = (state_q == PULSE);
  assign lcd_rw = 1'b0;
  assign busy   = (state_q != IDLE) || !fifo_empty || init_busy;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer; long wait shortened to 6000 cycles to keep run time small.
module tb_lcd_byte_writer;
  localparam int SETUP_CYC      = 2;
  localparam int EN_CYC         = 25;
  localparam int HOLD_CYC       = 2;
  localparam int SHORT_WAIT_CYC = 2500;
  localparam int LONG_WAIT_CYC  = 6000;
  localparam int FIFO_DEPTH     = 4;
  localparam int POWERUP_CYC    = 100;

  // hand-computed cycle numbers relative to the accepting edge 0
  localparam int EN_FIRST   = 3;
  localparam int EN_LAST    = 27;
  localparam int DONE_SHORT = 2530;
  localparam int DONE_LONG  = 6030;

  localparam logic [7:0] WS_DATA [4] = '{8'h02, 8'h03, 8'h04, 8'h00};
  localparam int         WS_DONE [4] = '{6030, 6030, 2530, 2530};

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  int         errors;
  int         checks;

  lcd_byte_writer_if u_if ();

  lcd_byte_writer #(
    .SETUP_CYC      (SETUP_CYC),
    .EN_CYC         (EN_CYC),
    .HOLD_CYC       (HOLD_CYC),
    .SHORT_WAIT_CYC (SHORT_WAIT_CYC),
    .LONG_WAIT_CYC  (LONG_WAIT_CYC),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .POWERUP_CYC    (POWERUP_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (u_if.slave),
    .busy     (busy),
    .lcd_data (lcd_data),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EN rising-edge log, bus stability during EN, and lcd_rw watch
  logic [8:0] en_log [$];
  logic       en_prev;
  logic [8:0] bus_prev;
  int         glitches;
  int         rw_bad;

  initial begin
    en_prev  = 1'b0;
    bus_prev = '0;
    glitches = 0;
    rw_bad   = 0;
  end

  always @(negedge clk) begin
    if (lcd_en === 1'b1 && en_prev !== 1'b1) en_log.push_back({lcd_rs, lcd_data});
    if (lcd_en === 1'b1 && en_prev === 1'b1 && {lcd_rs, lcd_data} !== bus_prev) glitches++;
    if (lcd_rw !== 1'b0) rw_bad++;
    en_prev  = lcd_en;
    bus_prev = {lcd_rs, lcd_data};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic rs, input logic [7:0] data);
    u_if.in_rs    = rs;
    u_if.in_data  = data;
    u_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    step(2);
    checks++;
    if ({lcd_en, lcd_rs, lcd_data, lcd_rw, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b rs=%b data=%h rw=%b busy=%b, expected all 0",
               lcd_en, lcd_rs, lcd_data, lcd_rw, busy);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", u_if.in_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_char;
    push_one(1'b1, 8'h41);
    step(1);
    checks++;
    if ({lcd_rs, lcd_data, lcd_en, busy} !== {1'b1, 8'h41, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL char_bus_load: got rs=%b data=%h en=%b busy=%b expected rs=1 data=41 en=0 busy=1",
               lcd_rs, lcd_data, lcd_en, busy);
    end
    step(EN_FIRST - 2);
    checks++;
    if (lcd_en !== 1'b0) begin
      errors++;
      $display("FAIL char_en_setup: cycle 2 got en=%b expected 0", lcd_en);
    end
    step(1);
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL char_en_rise: cycle 3 got en=%b expected 1", lcd_en);
    end
    step(EN_LAST - EN_FIRST);
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL char_en_last: cycle 27 got en=%b expected 1", lcd_en);
    end
    step(1);
    checks++;
    if ({lcd_en, lcd_data} !== {1'b0, 8'h41}) begin
      errors++;
      $display("FAIL char_hold: cycle 28 got en=%b data=%h expected en=0 data=41", lcd_en, lcd_data);
    end
    step(DONE_SHORT - 1 - (EN_LAST + 1));
    checks++;
    if ({busy, lcd_rs, lcd_data} !== {1'b1, 1'b1, 8'h41}) begin
      errors++;
      $display("FAIL char_wait_end: cycle 2529 got busy=%b rs=%b data=%h expected busy=1 rs=1 data=41",
               busy, lcd_rs, lcd_data);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL char_done: cycle 2530 got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_clear;
    push_one(1'b0, 8'h01);
    step(EN_FIRST);
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL clear_en_rise: got en=%b expected 1", lcd_en);
    end
    step(EN_LAST + 1 - EN_FIRST);
    checks++;
    if (lcd_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_en_fall: cycle 28 got en=%b expected 0", lcd_en);
    end
    step(DONE_SHORT - (EN_LAST + 1));
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_long_wait: cycle 2530 got busy=%b expected 1", busy);
    end
    step(DONE_LONG - 1 - DONE_SHORT);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_wait_end: cycle 6029 got busy=%b expected 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: cycle 6030 got busy=%b expected 0", busy);
    end
    // 0x01 as character data is not a clear
    push_one(1'b1, 8'h01);
    step(DONE_SHORT - 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL char01_wait_end: got busy=%b expected 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL char01_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_wait_select;
    for (int i = 0; i < 4; i++) begin
      push_one(1'b0, WS_DATA[i]);
      step(WS_DONE[i] - 1);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_sel_%h_before: got busy=%b expected 1", WS_DATA[i], busy);
      end
      step(1);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL wait_sel_%h_done: got busy=%b expected 0", WS_DATA[i], busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic ok;
    en_log.delete();
    u_if.in_rs    = 1'b1;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u_if.in_data = 8'(8'h41 + i);
      checks++;
      if (u_if.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_%0d: got %b expected 1", i, u_if.in_ready);
      end
      @(posedge clk);
      #1;
    end
    // cycle 4: B..E fill all four entries
    u_if.in_data = 8'h46;
    checks++;
    if (u_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: cycle 4 got in_ready=%b expected 0", u_if.in_ready);
    end
    step(DONE_SHORT - 4);
    checks++;
    if (u_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_still_full: cycle 2530 got in_ready=%b expected 0", u_if.in_ready);
    end
    step(1);
    checks++;
    if (u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_slot_free: cycle 2531 got in_ready=%b expected 1", u_if.in_ready);
    end
    step(1);
    u_if.in_valid = 1'b0;
    wait_idle(6 * 2600, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: busy still %b after budget, expected 0", busy);
    end
    checks++;
    if (en_log.size() != 6) begin
      errors++;
      $display("FAIL bp_pulse_count: got %0d pulses expected 6", en_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (en_log[i] !== {1'b1, 8'(8'h41 + i)}) begin
          errors++;
          $display("FAIL bp_order_%0d: got %h expected %h", i, en_log[i], {1'b1, 8'(8'h41 + i)});
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse;
    en_log.delete();
    u_if.in_rs    = 1'b1;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.in_data = 8'(8'h50 + i);
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b0;
    step(7);
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pulse_active: cycle 10 got en=%b expected 1", lcd_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lcd_en, lcd_rs, lcd_data, busy} !== 11'h000) begin
      errors++;
      $display("FAIL rst_async: got en=%b rs=%b data=%h busy=%b expected all 0", lcd_en, lcd_rs, lcd_data, busy);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({u_if.in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_release: got in_ready=%b busy=%b expected in_ready=1 busy=0", u_if.in_ready, busy);
    end
    step(3000);
    checks++;
    if (en_log.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: got %0d pulses busy=%b expected 1 pulse busy=0", en_log.size(), busy);
    end
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init;
    logic [8:0] exp_init [4];
    int         waited;
    exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006};
    en_log.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({u_if.in_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL init_start: got in_ready=%b busy=%b expected in_ready=0 busy=1", u_if.in_ready, busy);
    end
    waited = 0;
    while (u_if.in_ready !== 1'b1 && waited < 20000) begin
      step(1);
      waited++;
    end
    checks++;
    if (u_if.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done: got in_ready=%b busy=%b expected in_ready=1 busy=0", u_if.in_ready, busy);
    end
    checks++;
    if (en_log.size() != 4) begin
      errors++;
      $display("FAIL init_count: got %0d pulses expected 4", en_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (en_log[i] !== exp_init[i]) begin
          errors++;
          $display("FAIL init_byte_%0d: got %h expected %h", i, en_log[i], exp_init[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_bus_integrity;
    checks++;
    if (rw_bad != 0) begin
      errors++;
      $display("FAIL rw_low: lcd_rw nonzero on %0d cycles, expected 0", rw_bad);
    end
    checks++;
    if (glitches != 0) begin
      errors++;
      $display("FAIL bus_stable_en: %0d bus changes while EN high, expected 0", glitches);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_rs    = 1'b0;
    u_if.in_data  = 8'h00;
`ifdef LCD_INIT_SEQ_EN
    test_init;
`else
    test_reset;
    test_single_char;
    test_clear;
    test_wait_select;
    test_back_to_back;
    test_reset_mid_pulse;
`endif
    test_bus_integrity;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
